// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package sub_pkg;

  localparam int unsigned SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fs_bh.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out of the bit.
module fs_bh (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
module serial_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, d_r;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb, b_msb;
  logic             bit_d, bit_b;

  fs_bh u_fs (
    .x    (a_r[0]),
    .y    (b_r[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      d_r   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          d_r <= {bit_d, d_r[WIDTH-1:1]};
          a_r <= a_r >> 1;
          b_r <= b_r >> 1;
          br  <= bit_b;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The final borrow register is the borrow-out; the captured sign bits keep
  // ovf stable after the operand registers have been shifted out.
  assign d    = d_r;
  assign bout = br;
  assign ovf  = (a_msb != b_msb) && (d_r[WIDTH-1] != a_msb);

endmodule
